// File: rtl/host_cmd_serializer_if.sv
// Command handshake and serial line bundle for host_cmd_serializer.
// master = command source, slave = serializer.
interface host_cmd_serializer_if #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 8,
  parameter int FUN_WIDTH  = 4
);
  logic                  CMD_VALID;
  logic                  CMD_READY;
  logic [1:0]            CMD_TYPE;
  logic [ADDR_WIDTH-1:0] CMD_ADDR;
  logic [DATA_WIDTH-1:0] CMD_DATA0;
  logic [DATA_WIDTH-1:0] CMD_DATA1;
  logic [FUN_WIDTH-1:0]  CMD_FUN;
  logic                  PAR_EN;
  logic                  PAR_TYP;
  logic [7:0]            BIT_PERIOD;
  logic                  TX_OUT;
  logic                  BUSY;
  logic                  FRAME_DONE;

  modport master (
    output CMD_VALID, CMD_TYPE, CMD_ADDR, CMD_DATA0,
    output CMD_DATA1, CMD_FUN, PAR_EN, PAR_TYP, BIT_PERIOD,
    input  CMD_READY, TX_OUT, BUSY, FRAME_DONE
  );

  modport slave (
    input  CMD_VALID, CMD_TYPE, CMD_ADDR, CMD_DATA0,
    input  CMD_DATA1, CMD_FUN, PAR_EN, PAR_TYP, BIT_PERIOD,
    output CMD_READY, TX_OUT, BUSY, FRAME_DONE
  );
endinterface

// File: rtl/host_cmd_serializer.sv
// Expands one host command into controller bytes and sends them as UART frames.
// Optional HOST_CMD_GAP_EN inserts GAP_BITS idle bit periods after each byte.
module host_cmd_serializer #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 8,
  parameter int FUN_WIDTH  = 4,
  parameter int GAP_BITS   = 2
) (
  input logic                  CLK,
  input logic                  RST,
  host_cmd_serializer_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PARITY, S_STOP
`ifdef HOST_CMD_GAP_EN
    , S_GAP
`endif
  } state_t;

  state_t                r_state, w_nxt_state;
  logic [7:0]            r_cnt, w_nxt_cnt;
  logic [2:0]            r_bit, w_nxt_bit;
  logic [1:0]            r_idx, w_nxt_idx;
  logic [7:0]            r_shift, w_nxt_shift;
  logic                  r_par, w_nxt_par;
  logic                  r_tx, w_nxt_tx;
  logic                  r_done, w_nxt_done;
`ifdef HOST_CMD_GAP_EN
  logic [7:0]            r_gap, w_nxt_gap;
`else
  logic                  w_unused_gap;
  assign w_unused_gap = ^GAP_BITS;
`endif

  logic [1:0]            r_type;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_d0, r_d1;
  logic [FUN_WIDTH-1:0]  r_fun;
  logic                  r_pen, r_ptyp;
  logic [7:0]            r_bp;

  logic       w_accept, w_tick, w_last;
  logic [7:0] w_byte;
  logic [1:0] w_last_idx;

  assign w_accept = bus.CMD_VALID && (r_state == S_IDLE);
  assign w_tick   = (r_cnt == r_bp - 8'd1);
  assign w_last   = (r_idx == w_last_idx);

  assign bus.CMD_READY  = (r_state == S_IDLE);
  assign bus.BUSY       = (r_state != S_IDLE);
  assign bus.TX_OUT     = r_tx;
  assign bus.FRAME_DONE = r_done;

  // Byte to send for the current command type and byte index
  always_comb begin
    w_byte     = 8'h00;
    w_last_idx = 2'd1;
    case (r_type)
      2'd0: begin
        w_last_idx = 2'd2;
        case (r_idx)
          2'd0:    w_byte = 8'hAA;
          2'd1:    w_byte = 8'(r_addr);
          default: w_byte = 8'(r_d0);
        endcase
      end
      2'd1: w_byte = (r_idx == 2'd0) ? 8'hBB : 8'(r_addr);
      2'd2: begin
        w_last_idx = 2'd3;
        case (r_idx)
          2'd0:    w_byte = 8'hCC;
          2'd1:    w_byte = 8'(r_d0);
          2'd2:    w_byte = 8'(r_d1);
          default: w_byte = 8'(r_fun);
        endcase
      end
      default: w_byte = (r_idx == 2'd0) ? 8'hDD : 8'(r_fun);
    endcase
  end

  // Next-state, counters and next serial level
  always_comb begin
    w_nxt_state = r_state;
    w_nxt_cnt   = r_cnt;
    w_nxt_bit   = r_bit;
    w_nxt_idx   = r_idx;
    w_nxt_shift = r_shift;
    w_nxt_par   = r_par;
    w_nxt_tx    = r_tx;
    w_nxt_done  = 1'b0;
`ifdef HOST_CMD_GAP_EN
    w_nxt_gap   = r_gap;
`endif
    if (r_state != S_IDLE)
      w_nxt_cnt = w_tick ? 8'd0 : r_cnt + 8'd1;
    case (r_state)
      S_IDLE: begin
        w_nxt_tx = 1'b1;
        if (w_accept) begin
          w_nxt_state = S_START;
          w_nxt_tx    = 1'b0;
          w_nxt_cnt   = 8'd0;
          w_nxt_idx   = 2'd0;
          w_nxt_bit   = 3'd0;
        end
      end
      S_START: if (w_tick) begin
        w_nxt_state = S_DATA;
        w_nxt_tx    = w_byte[0];
        w_nxt_shift = {1'b0, w_byte[7:1]};
        w_nxt_par   = ^w_byte ^ r_ptyp;
        w_nxt_bit   = 3'd0;
      end
      S_DATA: if (w_tick) begin
        if (r_bit == 3'd7) begin
          w_nxt_state = r_pen ? S_PARITY : S_STOP;
          w_nxt_tx    = r_pen ? r_par : 1'b1;
        end else begin
          w_nxt_bit   = r_bit + 3'd1;
          w_nxt_tx    = r_shift[0];
          w_nxt_shift = {1'b0, r_shift[7:1]};
        end
      end
      S_PARITY: if (w_tick) begin
        w_nxt_state = S_STOP;
        w_nxt_tx    = 1'b1;
      end
`ifdef HOST_CMD_GAP_EN
      S_STOP: if (w_tick) begin
        w_nxt_state = S_GAP;
        w_nxt_tx    = 1'b1;
        w_nxt_gap   = 8'd0;
      end
      S_GAP: if (w_tick) begin
        if (r_gap == 8'(GAP_BITS - 1)) begin
          w_nxt_state = w_last ? S_IDLE : S_START;
          w_nxt_tx    = w_last;
          w_nxt_done  = w_last;
          w_nxt_idx   = w_last ? r_idx : r_idx + 2'd1;
        end else begin
          w_nxt_gap = r_gap + 8'd1;
        end
      end
`else
      S_STOP: if (w_tick) begin
        w_nxt_state = w_last ? S_IDLE : S_START;
        w_nxt_tx    = w_last;
        w_nxt_done  = w_last;
        w_nxt_idx   = w_last ? r_idx : r_idx + 2'd1;
      end
`endif
      default: w_nxt_state = S_IDLE;
    endcase
  end

  // FSM state, counters and registered serial output
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state <= S_IDLE;
      r_cnt   <= 8'd0;
      r_bit   <= 3'd0;
      r_idx   <= 2'd0;
      r_shift <= 8'd0;
      r_par   <= 1'b0;
      r_tx    <= 1'b1;
      r_done  <= 1'b0;
`ifdef HOST_CMD_GAP_EN
      r_gap   <= 8'd0;
`endif
    end else begin
      r_state <= w_nxt_state;
      r_cnt   <= w_nxt_cnt;
      r_bit   <= w_nxt_bit;
      r_idx   <= w_nxt_idx;
      r_shift <= w_nxt_shift;
      r_par   <= w_nxt_par;
      r_tx    <= w_nxt_tx;
      r_done  <= w_nxt_done;
`ifdef HOST_CMD_GAP_EN
      r_gap   <= w_nxt_gap;
`endif
    end
  end

  // Capture the command fields and line settings on acceptance
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_type <= 2'd0;
      r_addr <= '0;
      r_d0   <= '0;
      r_d1   <= '0;
      r_fun  <= '0;
      r_pen  <= 1'b0;
      r_ptyp <= 1'b0;
      r_bp   <= 8'd1;
    end else if (w_accept) begin
      r_type <= bus.CMD_TYPE;
      r_addr <= bus.CMD_ADDR;
      r_d0   <= bus.CMD_DATA0;
      r_d1   <= bus.CMD_DATA1;
      r_fun  <= bus.CMD_FUN;
      r_pen  <= bus.PAR_EN;
      r_ptyp <= bus.PAR_TYP;
      r_bp   <= (bus.BIT_PERIOD == 8'd0) ? 8'd1 : bus.BIT_PERIOD;
    end
  end

endmodule

// File: tb/tb_host_cmd_serializer.sv
// Scoreboard bench for host_cmd_serializer: stimulus queues expected bytes,
// a line monitor decodes UART frames on TX_OUT and compares.
module tb_host_cmd_serializer;

  localparam int GAP = 2;
`ifdef HOST_CMD_GAP_EN
  localparam int GAPC = GAP;
`else
  localparam int GAPC = 0;
`endif

  typedef struct {
    logic [7:0] b;
    logic       p;
    logic       pen;
    int         bp;
  } exp_t;

  logic CLK;
  logic RST;
  int   n_tests = 0;
  int   n_fail  = 0;
  exp_t q[$];

  host_cmd_serializer_if bus ();

  host_cmd_serializer #(.GAP_BITS(GAP)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] got,
                     input logic [31:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s got=%0h want=%0h", name, got, want);
    end
  endtask

  task automatic push(input logic [7:0] b, input logic p,
                      input logic pen, input logic [7:0] bp);
    exp_t e;
    e.b   = b;
    e.p   = p;
    e.pen = pen;
    e.bp  = (bp == 8'd0) ? 1 : int'(bp);
    q.push_back(e);
  endtask

  // Decode one frame whose start bit is visible at the current negedge
  task automatic decode();
    exp_t       e;
    int         nb;
    logic [10:0] bits;
    logic       stable, gap_ok;
    int         w;
    chk("frame_expected", q.size() != 0, 1);
    if (q.size() == 0) begin
      w = 0;
      while (bus.TX_OUT !== 1'b1 && w < 2000) begin
        @(negedge CLK);
        w++;
      end
      return;
    end
    e      = q[0];
    nb     = 10 + int'(e.pen);
    bits   = '0;
    stable = 1'b1;
    gap_ok = 1'b1;
    for (int i = 0; i < nb; i++) begin
      for (int c = 0; c < e.bp; c++) begin
        if (i != 0 || c != 0) @(negedge CLK);
        if (RST) return;
        if (c == 0) bits[i] = bus.TX_OUT;
        else if (bus.TX_OUT !== bits[i]) stable = 1'b0;
      end
    end
    for (int c = 0; c < GAPC * e.bp; c++) begin
      @(negedge CLK);
      if (RST) return;
      if (bus.TX_OUT !== 1'b1) gap_ok = 1'b0;
    end
    void'(q.pop_front());
    chk("data_byte", bits[8:1], e.b);
    if (e.pen) chk("parity_bit", bits[9], e.p);
    chk("frame_start_stop_stable_gap",
        {bits[0], bits[nb-1], stable, gap_ok}, 4'b0111);
  endtask

  initial begin : monitor
    forever begin
      @(negedge CLK);
      if (RST === 1'b0 && bus.TX_OUT === 1'b0) decode();
    end
  end

  task automatic scramble();
    bus.CMD_TYPE   = 2'($urandom);
    bus.CMD_ADDR   = 4'($urandom);
    bus.CMD_DATA0  = 8'($urandom);
    bus.CMD_DATA1  = 8'($urandom);
    bus.CMD_FUN    = 4'($urandom);
    bus.PAR_EN     = 1'($urandom);
    bus.PAR_TYP    = 1'($urandom);
    bus.BIT_PERIOD = 8'($urandom);
  endtask

  task automatic issue(input logic [1:0] t, input logic [3:0] a,
                       input logic [7:0] d0, input logic [7:0] d1,
                       input logic [3:0] f, input logic pen,
                       input logic pt, input logic [7:0] bp,
                       input bit hold);
    int w;
    w = 0;
    @(negedge CLK);
    while (!bus.CMD_READY && w < 2000) begin
      @(negedge CLK);
      w++;
    end
    chk("ready_before_issue", bus.CMD_READY, 1);
    bus.CMD_TYPE   = t;
    bus.CMD_ADDR   = a;
    bus.CMD_DATA0  = d0;
    bus.CMD_DATA1  = d1;
    bus.CMD_FUN    = f;
    bus.PAR_EN     = pen;
    bus.PAR_TYP    = pt;
    bus.BIT_PERIOD = bp;
    bus.CMD_VALID  = 1'b1;
    @(posedge CLK);
    #1;
    if (!hold) bus.CMD_VALID = 1'b0;
    bus.CMD_ADDR   = ~a;
    bus.CMD_DATA0  = ~d0;
    bus.CMD_DATA1  = ~d1;
    bus.CMD_FUN    = ~f;
    bus.PAR_EN     = ~pen;
    bus.PAR_TYP    = ~pt;
    bus.BIT_PERIOD = bp + 8'd1;
    @(negedge CLK);
    chk("start_tx_busy_ready",
        {bus.TX_OUT, bus.BUSY, bus.CMD_READY}, 3'b010);
  endtask

  task automatic wait_done(input int want, input bit hold);
    int         cyc;
    int         rdy;
    bit         seen;
    logic [1:0] st;
    cyc  = 0;
    rdy  = 0;
    seen = 1'b0;
    st   = 2'b11;
    while (!seen && cyc < want + 100) begin
      @(negedge CLK);
      cyc++;
      if (bus.FRAME_DONE) begin
        seen = 1'b1;
        st   = {bus.BUSY, bus.CMD_READY};
        bus.CMD_VALID = 1'b0;
      end else begin
        if (bus.CMD_READY) rdy++;
        if (hold) scramble();
      end
    end
    bus.CMD_VALID = 1'b0;
    chk("done_latency", seen ? cyc : 0, want);
    chk("done_busy_ready", st, 2'b01);
    chk("ready_low_while_busy", rdy, 0);
    @(negedge CLK);
    chk("done_one_cycle", bus.FRAME_DONE, 0);
  endtask

  function automatic int dur(input int nbytes, input int pen, input int bp);
    return nbytes * (10 + pen + GAPC) * bp;
  endfunction

  initial begin : stim
    RST            = 1'b1;
    bus.CMD_VALID  = 1'b0;
    bus.CMD_TYPE   = 2'd0;
    bus.CMD_ADDR   = 4'd0;
    bus.CMD_DATA0  = 8'd0;
    bus.CMD_DATA1  = 8'd0;
    bus.CMD_FUN    = 4'd0;
    bus.PAR_EN     = 1'b0;
    bus.PAR_TYP    = 1'b0;
    bus.BIT_PERIOD = 8'd1;
    #3;
    chk("reset_values",
        {bus.TX_OUT, bus.BUSY, bus.FRAME_DONE, bus.CMD_READY}, 4'b1001);
    repeat (3) @(negedge CLK);
    RST = 1'b0;

    push(8'hAA, 1'b0, 1'b0, 8'd4);
    push(8'h05, 1'b0, 1'b0, 8'd4);
    push(8'h3C, 1'b0, 1'b0, 8'd4);
    issue(2'd0, 4'h5, 8'h3C, 8'h00, 4'h0, 1'b0, 1'b0, 8'd4, 1'b0);
    wait_done(dur(3, 0, 4), 1'b0);

    push(8'hBB, 1'b0, 1'b1, 8'd2);
    push(8'h02, 1'b1, 1'b1, 8'd2);
    issue(2'd1, 4'h2, 8'h00, 8'h00, 4'h0, 1'b1, 1'b0, 8'd2, 1'b0);
    wait_done(dur(2, 1, 2), 1'b0);

    push(8'hCC, 1'b1, 1'b1, 8'd3);
    push(8'h0F, 1'b1, 1'b1, 8'd3);
    push(8'h01, 1'b0, 1'b1, 8'd3);
    push(8'h03, 1'b1, 1'b1, 8'd3);
    issue(2'd2, 4'h0, 8'h0F, 8'h01, 4'h3, 1'b1, 1'b1, 8'd3, 1'b0);
    wait_done(dur(4, 1, 3), 1'b0);

    push(8'hBB, 1'b0, 1'b0, 8'd3);
    push(8'h0E, 1'b0, 1'b0, 8'd3);
    issue(2'd1, 4'hE, 8'h00, 8'h00, 4'h0, 1'b0, 1'b0, 8'd3, 1'b1);
    wait_done(dur(2, 0, 3), 1'b1);

    push(8'hDD, 1'b0, 1'b0, 8'd0);
    push(8'h05, 1'b0, 1'b0, 8'd0);
    issue(2'd3, 4'h0, 8'h00, 8'h00, 4'h5, 1'b0, 1'b0, 8'd0, 1'b0);
    wait_done(dur(2, 0, 1), 1'b0);

    push(8'hAA, 1'b0, 1'b0, 8'd4);
    push(8'h07, 1'b0, 1'b0, 8'd4);
    push(8'h81, 1'b0, 1'b0, 8'd4);
    issue(2'd0, 4'h7, 8'h81, 8'h00, 4'h0, 1'b0, 1'b0, 8'd4, 1'b0);
    repeat ((10 + GAPC) * 4 + 4 * 4 + 1) @(negedge CLK);
    #2;
    RST = 1'b1;
    #1;
    chk("reset_mid_frame",
        {bus.TX_OUT, bus.BUSY, bus.CMD_READY, bus.FRAME_DONE}, 4'b1010);
    repeat (3) @(negedge CLK);
    chk("aborted_bytes_left", q.size(), 2);
    q.delete();
    RST = 1'b0;

    push(8'hDD, 1'b0, 1'b0, 8'd4);
    push(8'h08, 1'b0, 1'b0, 8'd4);
    issue(2'd3, 4'h0, 8'h00, 8'h00, 4'h8, 1'b0, 1'b0, 8'd4, 1'b0);
    wait_done(dur(2, 0, 4), 1'b0);

    repeat (20) @(negedge CLK);
    chk("scoreboard_empty", q.size(), 0);
    chk("line_idle_high", bus.TX_OUT, 1);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
